// File: rtl/stack_unit.sv
`default_nettype none
// ============================================================================
//  Module   : stack_unit
//  Purpose  : Owns SP (R3) updates; executes PUSH/POP/CALL/RET via req/ack memory.
//  Revision : 1.0 - initial release
// ============================================================================
module stack_unit #(
  parameter int            DW       = 8,
  parameter int            AW       = 8,
  parameter logic [AW-1:0] SP_RESET = 8'hFF,
  parameter logic [AW-1:0] SP_LIMIT = 8'h80
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic [1:0]    op,
  input  logic [DW-1:0] push_data,
  input  logic [DW-1:0] pc_in,
  input  logic [AW-1:0] sp_in,
  input  logic          rf_gpr_we,
  output logic [AW-1:0] sp_value,
  output logic          sp_write_enable,
  output logic [DW-1:0] pop_data,
  output logic          pop_valid,
  output logic [DW-1:0] pc_out,
  output logic          pc_load,
  output logic          op_done,
  output logic          op_err,
  output logic          err_overflow,
  output logic          err_underflow,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_mem  = 2'd1;
  localparam logic [1:0] c_st_upd  = 2'd2;
  localparam logic [1:0] c_st_err  = 2'd3;

  localparam logic [1:0] c_op_pop = 2'b01;
  localparam logic [1:0] c_op_ret = 2'b11;

  localparam logic [AW-1:0] c_sp_one = {{(AW-1){1'b0}}, 1'b1};

  logic [1:0]    r_state;
  logic [1:0]    w_next;
  logic [1:0]    r_op;
  logic [AW-1:0] r_sp;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_pop_data;
  logic [DW-1:0] r_pc_out;
  logic          r_err_ovf;
  logic          r_err_unf;

  logic w_accept;
  logic w_in_write;
  logic w_reject;
  logic w_q_write;
  logic w_upd_fire;

  // PUSH (00) and CALL (10) both write memory: op[0] clear
  assign w_in_write = ~op[0];
  assign w_q_write  = ~r_op[0];
  assign w_accept   = op_valid && (r_state == c_st_idle);
  assign w_reject   = w_in_write ? (sp_in < SP_LIMIT) : (sp_in == SP_RESET);
  assign w_upd_fire = (r_state == c_st_upd) && !rf_gpr_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_st_idle;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_st_idle: if (w_accept) w_next = w_reject ? c_st_err : c_st_mem;
      c_st_mem:  if (mem_ack) w_next = c_st_upd;
      c_st_upd:  if (!rf_gpr_we) w_next = c_st_idle;
      c_st_err:  w_next = c_st_idle;
      default:   w_next = c_st_idle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op       <= 2'b00;
      r_sp       <= '0;
      r_wdata    <= '0;
      r_pop_data <= '0;
      r_pc_out   <= '0;
      r_err_ovf  <= 1'b0;
      r_err_unf  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op    <= op;
        r_sp    <= sp_in;
        r_wdata <= op[1] ? pc_in : push_data;
        if (w_reject && w_in_write)  r_err_ovf <= 1'b1;
        if (w_reject && !w_in_write) r_err_unf <= 1'b1;
      end
      if ((r_state == c_st_mem) && mem_ack) begin
        if (r_op == c_op_pop) r_pop_data <= mem_rdata;
        if (r_op == c_op_ret) r_pc_out   <= mem_rdata;
      end
    end
  end

  always_comb begin
    op_ready        = (r_state == c_st_idle);
    mem_req         = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;
    sp_value        = '0;
    sp_write_enable = 1'b0;
    pop_valid       = 1'b0;
    pc_load         = 1'b0;
    op_done         = 1'b0;
    op_err          = 1'b0;
    case (r_state)
      c_st_mem: begin
        mem_req   = 1'b1;
        mem_we    = w_q_write;
        // SP names the next free slot, so the top item lives one above it
        mem_addr  = w_q_write ? r_sp : (r_sp + c_sp_one);
        mem_wdata = w_q_write ? r_wdata : '0;
      end
      c_st_upd: begin
        sp_value        = w_q_write ? (r_sp - c_sp_one) : (r_sp + c_sp_one);
        sp_write_enable = w_upd_fire;
        op_done         = w_upd_fire;
        pop_valid       = w_upd_fire && (r_op == c_op_pop);
        pc_load         = w_upd_fire && (r_op == c_op_ret);
      end
      c_st_err: begin
        op_done = 1'b1;
        op_err  = 1'b1;
      end
      default: ;
    endcase
  end

  assign pop_data      = r_pop_data;
  assign pc_out        = r_pc_out;
  assign err_overflow  = r_err_ovf;
  assign err_underflow = r_err_unf;

endmodule
`default_nettype wire

// File: tb/tb_stack_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stack_unit
//  Purpose  : Directed plus randomized checks of stack_unit against a stack model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stack_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       op_valid;
  logic       op_ready;
  logic [1:0] op;
  logic [7:0] push_data;
  logic [7:0] pc_in;
  logic [7:0] sp_in;
  logic       rf_gpr_we;
  logic [7:0] sp_value;
  logic       sp_write_enable;
  logic [7:0] pop_data;
  logic       pop_valid;
  logic [7:0] pc_out;
  logic       pc_load;
  logic       op_done;
  logic       op_err;
  logic       err_overflow;
  logic       err_underflow;
  logic       mem_req;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       mem_ack;

  stack_unit dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .op(op),
    .push_data(push_data), .pc_in(pc_in), .sp_in(sp_in), .rf_gpr_we(rf_gpr_we),
    .sp_value(sp_value), .sp_write_enable(sp_write_enable), .pop_data(pop_data),
    .pop_valid(pop_valid), .pc_out(pc_out), .pc_load(pc_load), .op_done(op_done),
    .op_err(op_err), .err_overflow(err_overflow), .err_underflow(err_underflow),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: memory contents, register-file SP, sticky flags, held results
  logic [7:0] m_mem [256];
  logic [7:0] m_sp;
  logic       m_ovf, m_unf;
  logic [7:0] m_pop, m_pc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic do_op(input logic [1:0] t_op, input logic [7:0] t_data,
                       input logic [7:0] t_pc, input logic [7:0] t_sp,
                       input int ack_dly, input int hold);
    logic       is_wr, reject;
    logic [7:0] addr, wdat, rdat, new_sp;
    is_wr  = (t_op == 2'b00) || (t_op == 2'b10);
    reject = is_wr ? (t_sp < 8'h80) : (t_sp == 8'hFF);
    addr   = is_wr ? t_sp : t_sp + 8'd1;
    new_sp = is_wr ? t_sp - 8'd1 : t_sp + 8'd1;
    wdat   = (t_op == 2'b10) ? t_pc : t_data;
    @(negedge clk);
    check("ready_idle", op_ready, 1);
    op_valid = 1'b1; op = t_op; push_data = t_data; pc_in = t_pc; sp_in = t_sp;
    @(negedge clk);
    op_valid = 1'b0; push_data = $urandom; pc_in = $urandom; sp_in = $urandom;
    if (reject) begin
      check("err_done", op_done, 1);
      check("err_flag", op_err, 1);
      check("err_noreq", mem_req, 0);
      check("err_nowe", sp_write_enable, 0);
      if (is_wr) m_ovf = 1'b1; else m_unf = 1'b1;
      @(negedge clk);
      check("err_done_end", op_done, 0);
      check("err_ready", op_ready, 1);
    end else begin
      for (int k = 0; k <= ack_dly; k++) begin
        check("mem_req", mem_req, 1);
        check("mem_we", mem_we, is_wr);
        check("mem_addr", mem_addr, addr);
        if (is_wr) check("mem_wdata", mem_wdata, wdat);
        check("busy_ready", op_ready, 0);
        check("busy_done", op_done, 0);
        op_valid = 1'($urandom_range(0, 1));
        op = 2'($urandom);
        sp_in = (k == 0) ? 8'hFF : 8'h00;
        if (k == ack_dly) begin
          mem_ack = 1'b1;
          mem_rdata = is_wr ? 8'($urandom) : m_mem[addr];
        end
        @(negedge clk);
      end
      mem_ack = 1'b0; mem_rdata = $urandom;
      rdat = m_mem[addr];
      if (is_wr) m_mem[addr] = wdat;
      else if (t_op == 2'b01) m_pop = rdat;
      else m_pc = rdat;
      for (int k = 0; k < hold; k++) begin
        rf_gpr_we = 1'b1;
        op_valid = 1'($urandom_range(0, 1));
        #1;
        check("hold_nowe", sp_write_enable, 0);
        check("hold_nodone", op_done, 0);
        check("hold_noreq", mem_req, 0);
        @(negedge clk);
      end
      rf_gpr_we = 1'b0; op_valid = 1'b0;
      #1;
      check("sp_we", sp_write_enable, 1);
      check("sp_value", sp_value, new_sp);
      check("done", op_done, 1);
      check("done_noerr", op_err, 0);
      check("pop_valid", pop_valid, t_op == 2'b01);
      check("pc_load", pc_load, t_op == 2'b11);
      if (t_op == 2'b01) check("pop_data", pop_data, m_pop);
      if (t_op == 2'b11) check("pc_out", pc_out, m_pc);
      m_sp = new_sp;
      @(negedge clk);
      check("done_end", op_done, 0);
      check("we_end", sp_write_enable, 0);
      check("ready_end", op_ready, 1);
    end
    check("ovf", err_overflow, m_ovf);
    check("unf", err_underflow, m_unf);
    check("pop_hold", pop_data, m_pop);
    check("pc_hold", pc_out, m_pc);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) m_mem[i] = 8'($urandom);
    m_sp = 8'hFF; m_ovf = 1'b0; m_unf = 1'b0; m_pop = 8'h00; m_pc = 8'h00;
    rst = 1'b1; op_valid = 1'b0; op = 2'b00; push_data = '0; pc_in = '0; sp_in = 8'hFF;
    rf_gpr_we = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", op_ready, 1);
    check("rst_req", mem_req, 0);
    check("rst_we", sp_write_enable, 0);
    check("rst_done", op_done, 0);
    check("rst_flags", {err_overflow, err_underflow}, 0);
    check("rst_pop", pop_data, 0);
    rst = 1'b0;

    do_op(2'b00, 8'h5A, 8'h00, 8'hFF, 0, 0);   // PUSH 5A, immediate ack
    do_op(2'b01, 8'h00, 8'h00, 8'hFE, 3, 0);   // POP, ack after 3 cycles
    check("pop_5a", m_pop, 8'h5A);
    do_op(2'b10, 8'h00, 8'h23, 8'hFF, 0, 0);   // CALL
    do_op(2'b11, 8'h00, 8'h00, 8'hFE, 1, 0);   // RET
    check("ret_23", m_pc, 8'h23);
    do_op(2'b01, 8'h00, 8'h00, 8'hFF, 0, 0);   // underflow
    do_op(2'b00, 8'h11, 8'h00, 8'h7F, 0, 0);   // overflow
    do_op(2'b00, 8'h80, 8'h00, 8'h80, 0, 0);   // last legal slot
    do_op(2'b00, 8'h77, 8'h00, 8'hFF, 0, 4);   // GPR write collision

    // Reset while the memory request is outstanding
    @(negedge clk);
    op_valid = 1'b1; op = 2'b00; push_data = 8'hC3; sp_in = 8'hFF;
    @(negedge clk);
    op_valid = 1'b0;
    check("abort_req_pre", mem_req, 1);
    #2 rst = 1'b1;
    #1;
    check("abort_req", mem_req, 0);
    check("abort_ready", op_ready, 1);
    check("abort_flags", {err_overflow, err_underflow}, 0);
    @(posedge clk); #1;
    check("abort_nowe", sp_write_enable, 0);
    @(negedge clk);
    check("abort_nodone", op_done, 0);
    rst = 1'b0;
    m_sp = 8'hFF; m_ovf = 1'b0; m_unf = 1'b0; m_pop = 8'h00; m_pc = 8'h00;

    for (int n = 0; n < 300; n++) begin
      logic [1:0] r_op;
      logic [7:0] r_sp;
      r_op = 2'($urandom);
      r_sp = ($urandom_range(0, 9) < 8) ? m_sp : 8'($urandom);
      do_op(r_op, 8'($urandom), 8'($urandom), r_sp,
            $urandom_range(0, 3), ($urandom_range(0, 9) < 7) ? 0 : $urandom_range(1, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
